// File: rtl/eth_10base_t_rx.sv
// 10BASE-T Manchester receiver: synchronizes the line, recovers mid-bit edges and delivers bytes.
// Optional macro ETH_RX_CRC_EN adds a CRC-32 check of each frame (FCS included) into rx_err.
module eth_10base_t_rx #(
  parameter int BIT_CLKS = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_d,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       led_rx
);

  localparam int MASK_CLKS = (3 * BIT_CLKS) / 4;
  localparam int LOSS_CLKS = (3 * BIT_CLKS) / 2;
  localparam int CW        = $clog2(LOSS_CLKS + 1);
  localparam logic [CW-1:0] MASK_C = CW'(MASK_CLKS);
  localparam logic [CW-1:0] LOSS_C = CW'(LOSS_CLKS);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            rx_meta_r;
  logic            rx_sync_r;
  logic            rx_prev_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      shift_r;
  logic [2:0]      bit_cnt_r;
  logic            last_bit_r;
  logic            byte_seen_r;
  logic            edge_s;
  logic            accept_s;
  logic            loss_s;
  logic            bit_s;
  logic [7:0]      byte_s;
  logic            crc_bad_s;

`ifdef ETH_RX_CRC_EN
  logic [31:0]     crc_r;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) begin
        c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  assign crc_bad_s = (crc_r != 32'hC704_DD7B);
`else
  assign crc_bad_s = 1'b0;
`endif

  // Edges inside the mask window are bit-boundary edges and are ignored.
  assign edge_s   = rx_sync_r ^ rx_prev_r;
  assign accept_s = edge_s && ((state_r == IDLE) || (cnt_r >= MASK_C));
  assign loss_s   = (state_r != IDLE) && !accept_s && (cnt_r >= LOSS_C);
  assign bit_s    = rx_sync_r;
  assign byte_s   = {bit_s, shift_r[7:1]};

  // Line synchronizer and edge-detect history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_r <= 1'b0;
      rx_sync_r <= 1'b0;
      rx_prev_r <= 1'b0;
    end else begin
      rx_meta_r <= rx_d;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Cycles since the last accepted edge, saturating at the carrier-loss limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (state_s == IDLE) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= ONE_C;
    end else if (cnt_r < LOSS_C) begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; two decoded 1s in a row mark the end of the SFD.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_s = PREAMBLE;
        end else begin
          state_s = IDLE;
        end
      end
      PREAMBLE: begin
        if (loss_s) begin
          state_s = IDLE;
        end else if (accept_s && bit_s && last_bit_r) begin
          state_s = DATA;
        end else begin
          state_s = PREAMBLE;
        end
      end
      DATA: begin
        if (loss_s) begin
          state_s = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Bit shifting, byte delivery and end-of-frame reporting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_sof      <= 1'b0;
      rx_eof      <= 1'b0;
      rx_err      <= 1'b0;
      led_rx      <= 1'b0;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      last_bit_r  <= 1'b0;
      byte_seen_r <= 1'b0;
`ifdef ETH_RX_CRC_EN
      crc_r       <= 32'hFFFF_FFFF;
`endif
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
      led_rx   <= (state_s != IDLE);

      if (accept_s) begin
        last_bit_r <= bit_s;
      end else if (state_r == IDLE) begin
        last_bit_r <= 1'b0;
      end

      if ((state_r == PREAMBLE) && (state_s == DATA)) begin
        shift_r     <= 8'h00;
        bit_cnt_r   <= 3'd0;
        byte_seen_r <= 1'b0;
`ifdef ETH_RX_CRC_EN
        crc_r       <= 32'hFFFF_FFFF;
`endif
      end else if ((state_r == DATA) && accept_s) begin
        shift_r   <= byte_s;
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          rx_data     <= byte_s;
          rx_valid    <= 1'b1;
          rx_sof      <= !byte_seen_r;
          byte_seen_r <= 1'b1;
`ifdef ETH_RX_CRC_EN
          crc_r       <= crc32_byte(crc_r, byte_s);
`endif
        end
      end else if ((state_r == DATA) && loss_s) begin
        // A frame that never completed a byte ends silently.
        rx_eof <= byte_seen_r;
        rx_err <= byte_seen_r && ((bit_cnt_r != 3'd0) || crc_bad_s);
      end
    end
  end

endmodule

// File: tb/tb_eth_10base_t_rx.sv
// Randomized self-checking bench for eth_10base_t_rx: Manchester line driver, output monitor,
// and a frame-level reference model (expected bytes, sof, eof/err from dribble and CRC residue).
module tb_eth_10base_t_rx;

  localparam int BIT_CLKS = 10;
  localparam int HALF     = BIT_CLKS / 2;
`ifdef ETH_RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_d;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;
  logic       led_rx;

  int checks   = 0;
  int failures = 0;

  logic [7:0] frame_q[$];
  logic [7:0] got_q[$];
  logic       got_sof_q[$];
  logic       got_err_q[$];
  int         overlap_cnt;
  int         stray_cnt;
  int         led_drop_cnt;
  bit         in_frame;
  logic       led_mid;

  always #5 clk = ~clk;

  eth_10base_t_rx #(.BIT_CLKS(BIT_CLKS)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_d     (rx_d),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_sof   (rx_sof),
    .rx_eof   (rx_eof),
    .rx_err   (rx_err),
    .led_rx   (led_rx)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_sof_q.push_back(rx_sof);
      in_frame = 1'b1;
    end
    if (rx_eof) begin
      got_err_q.push_back(rx_err);
      in_frame = 1'b0;
    end
    if (rx_valid && rx_eof) overlap_cnt++;
    if (rx_sof && !rx_valid) stray_cnt++;
    if (rx_err && !rx_eof) stray_cnt++;
    if (in_frame && !led_rx) led_drop_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Manchester bit: first half is the complement, mid-bit transition to the bit value.
  task automatic send_bit(input logic b, input bit jit);
    int j;
    j = jit ? (int'($urandom_range(2, 0)) - 1) : 0;
    rx_d = ~b;
    repeat (HALF) @(negedge clk);
    rx_d = b;
    repeat (HALF + j) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit jit);
    for (int i = 0; i < 8; i++) send_bit(v[i], jit);
  endtask

  task automatic clear_monitor();
    got_q.delete();
    got_sof_q.delete();
    got_err_q.delete();
    overlap_cnt  = 0;
    stray_cnt    = 0;
    led_drop_cnt = 0;
    in_frame     = 1'b0;
  endtask

  // Reflected CRC-32 over the whole frame; a good FCS leaves the register at 0xDEBB20E3.
  function automatic bit frame_crc_ok();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frame_q[i]) begin
      c = c ^ {24'h0, frame_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c == 32'hDEBB_20E3;
  endfunction

  function automatic logic [31:0] payload_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frame_q[i]) begin
      c = c ^ {24'h0, frame_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic run_frame(input string tag, input int extra, input bit jit);
    bit   exp_err;
    int   n;
    clear_monitor();
    for (int k = 0; k < 7; k++) begin
      send_byte(8'h55, jit);
      if (k == 2) led_mid = led_rx;
    end
    send_byte(8'hD5, jit);
    foreach (frame_q[i]) send_byte(frame_q[i], jit);
    for (int e = 0; e < extra; e++) send_bit(1'($urandom_range(1, 0)), jit);
    repeat (30) @(negedge clk);
    rx_d = 1'b0;
    repeat (40) @(negedge clk);
    exp_err = (extra != 0) || (CRC_EN && !frame_crc_ok());
    check_eq({tag, ":nbytes"}, 32'(got_q.size()), 32'(frame_q.size()));
    n = (got_q.size() < frame_q.size()) ? got_q.size() : frame_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s:byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, frame_q[i]});
      check_eq($sformatf("%s:sof%0d", tag, i), {31'h0, got_sof_q[i]}, {31'h0, (i == 0)});
    end
    check_eq({tag, ":neof"}, 32'(got_err_q.size()), 32'd1);
    if (got_err_q.size() > 0) check_eq({tag, ":err"}, {31'h0, got_err_q[0]}, {31'h0, exp_err});
    check_eq({tag, ":overlap"}, 32'(overlap_cnt), 32'd0);
    check_eq({tag, ":stray"}, 32'(stray_cnt), 32'd0);
    check_eq({tag, ":led_drop"}, 32'(led_drop_cnt), 32'd0);
    check_eq({tag, ":led_mid"}, {31'h0, led_mid}, 32'd1);
    check_eq({tag, ":led_end"}, {31'h0, led_rx}, 32'd0);
  endtask

  task automatic build_crc_frame(input int flip);
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < 60; i++) frame_q.push_back(8'($urandom_range(255, 0)));
    fcs = payload_fcs();
    for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
    if (flip >= 0) frame_q[10] = frame_q[10] ^ (8'h01 << flip);
  endtask

  initial begin
    int len;
    resetn = 1'b0;
    rx_d   = 1'b0;
    led_mid = 1'b0;
    clear_monitor();
    repeat (5) @(negedge clk);
    check_eq("rst:data", {24'h0, rx_data}, 32'h0);
    check_eq("rst:strobes", {28'h0, rx_valid, rx_sof, rx_eof, rx_err}, 32'h0);
    check_eq("rst:led", {31'h0, led_rx}, 32'h0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    frame_q = {8'h55, 8'hAA, 8'h0F};
    run_frame("basic", 0, 1'b0);

    build_crc_frame(-1);
    run_frame("crc_good", 0, 1'b0);
    build_crc_frame(3);
    run_frame("crc_bad", 0, 1'b0);

    frame_q = {8'hC3, 8'h3C, 8'h81, 8'h7E};
    run_frame("dribble", 2, 1'b0);

    // Preamble only, no SFD.
    clear_monitor();
    for (int i = 0; i < 20; i++) begin
      send_bit(1'(i % 2 == 0), 1'b0);
      if (i == 10) led_mid = led_rx;
    end
    repeat (40) @(negedge clk);
    check_eq("nosfd:nbytes", 32'(got_q.size()), 32'd0);
    check_eq("nosfd:neof", 32'(got_err_q.size()), 32'd0);
    check_eq("nosfd:led_mid", {31'h0, led_mid}, 32'd1);
    check_eq("nosfd:led_end", {31'h0, led_rx}, 32'd0);

    // Reset in the middle of the second byte of a frame.
    clear_monitor();
    for (int k = 0; k < 7; k++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'(i % 2), 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_eq("midrst:data", {24'h0, rx_data}, 32'h0);
    check_eq("midrst:strobes", {28'h0, rx_valid, rx_sof, rx_eof, rx_err}, 32'h0);
    check_eq("midrst:led", {31'h0, led_rx}, 32'h0);
    rx_d = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("midrst:nbytes", 32'(got_q.size()), 32'd1);
    check_eq("midrst:neof", 32'(got_err_q.size()), 32'd0);
    frame_q = {8'h12, 8'h34, 8'h56};
    run_frame("after_rst", 0, 1'b0);

    frame_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame("jitter", 0, 1'b1);

    for (int f = 0; f < 8; f++) begin
      frame_q.delete();
      len = int'($urandom_range(6, 1));
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(255, 0)));
      run_frame($sformatf("rand%0d", f), (f % 2 == 1) ? int'($urandom_range(7, 1)) : 0,
                1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_10base_t_rx.md
ETH_10BASE_T_RX -- requirements
Module: eth_10base_t_rx

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 10, clk cycles per 100 ns bit cell; even and >= 8.
REQ-002 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_d  input  1  received Manchester line level (comparator output of RX+/RX-), asynchronous.
REQ-005 SHALL have port rx_data  output  8  received byte.
REQ-006 SHALL have port rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-007 SHALL have port rx_sof  output  1  high with rx_valid of the first byte after SFD.
REQ-008 SHALL have port rx_eof  output  1  one-cycle strobe at end of frame.
REQ-009 SHALL have port rx_err  output  1  frame-error flag, valid only while rx_eof is high.
REQ-010 SHALL have port led_rx  output  1  high while a frame is being received.

Function
REQ-011 SHALL pass rx_d through a 2-flop synchronizer; all decoding uses the synchronized level.
REQ-012 SHALL have FSM states IDLE, PREAMBLE, DATA.
REQ-013 SHALL, in IDLE, move to PREAMBLE on any synchronized edge and treat it as a mid-bit edge.
REQ-014 SHALL decode a bit on each accepted mid-bit edge: bit = level after the edge (low-to-high = 1).
REQ-015 SHALL ignore all edges for 3*BIT_CLKS/4 cycles after an accepted edge (boundary edges masked).
REQ-016 SHALL declare carrier loss when no edge is accepted within 3*BIT_CLKS/2 cycles of the last accepted edge.
REQ-017 SHALL, in PREAMBLE, move to DATA when two consecutive decoded bits are 1 (SFD tail); carrier loss returns to IDLE with no outputs.
REQ-018 SHALL, in DATA, shift bits LSB-first; each 8th bit updates rx_data and pulses rx_valid for one cycle, within 2 cycles of the edge.
REQ-019 SHALL, on carrier loss in DATA, pulse rx_eof one cycle (never coincident with rx_valid) and return to IDLE.
REQ-020 SHALL set rx_err with rx_eof when 1..7 leftover bits remain (dribble); leftover bits are discarded.
REQ-021 SHALL, if carrier is lost in DATA before any byte is complete, return to IDLE with no rx_eof.
REQ-022 SHALL drive led_rx = (state != IDLE).
REQ-023 SHALL hold rx_valid, rx_sof, rx_eof, rx_err low in all other cycles.

Reset
REQ-024 SHALL, on resetn low, asynchronously clear state to IDLE, rx_data to 0x00, all strobes, rx_err and led_rx to 0, and all counters/shift registers to 0.
REQ-025 SHALL abort any frame in progress on reset with no rx_eof; after release, reception starts only at the next IDLE edge.

Configuration
REQ-026 SHALL, with macro ETH_RX_CRC_EN defined, run CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, LSB-first) over all DATA bytes incl. FCS and also set rx_err at rx_eof when residue != 0xC704DD7B.
REQ-027 SHALL, without ETH_RX_CRC_EN, contain no CRC logic; rx_err reflects dribble only.

Verification
REQ-028 SHALL cover: reset, 64-bit preamble+SFD, bytes 0x55,0xAA,0x0F, idle -> three rx_valid with those values, sof on first, one rx_eof with rx_err=0, led_rx high throughout.
REQ-029 SHALL cover: valid 64-byte frame with correct FCS, ETH_RX_CRC_EN defined -> rx_err=0; same frame with one payload bit flipped -> rx_err=1.
REQ-030 SHALL cover: frame with 2 extra bits after last byte -> last full byte delivered, rx_eof with rx_err=1.
REQ-031 SHALL cover: preamble of 20 bits then idle (no SFD) -> no rx_valid, no rx_eof, led_rx returns to 0.
REQ-032 SHALL cover: resetn asserted mid-byte in DATA -> all outputs 0 immediately, no rx_eof; next full frame received correctly.
REQ-033 SHALL cover: bit cell jitter of +/-1 clk at BIT_CLKS=10 on 0x00/0xFF runs -> bytes decoded without error.
